matrix_operand_bank: RTL

Operand-side responder for the MAC matrix multiplier. It holds matrix A (M×K) and matrix B (K×N), loads both from a host stream in row-major order, then starts the multiplier with `do_mac`. While the multiplier runs, the bank answers its A/B read requests with one-cycle registered data and waits for `mac_done` before returning to idle. It sits between the host/DMA loader and the MAC datapath, on the far side of the multiplier's operand read interface.

---
 rtl/matrix_operand_bank.sv | 123 ++++++++++++
 1 files changed

// File: rtl/matrix_operand_bank.sv
// Operand bank for the MAC matrix multiplier: streams A then B in from the host,
// starts the multiplier and serves its registered A/B read requests.
module matrix_operand_bank #(
  parameter int M                      = 4,
  parameter int K                      = 4,
  parameter int N                      = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              load_start,
  input  logic                              load_valid,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0] load_data,
  output logic                              load_ready,
  input  logic [$clog2(M)-1:0]              row_addr_a,
  input  logic [$clog2(K)-1:0]              col_addr_a,
  input  logic                              matrix_a_re,
  input  logic [$clog2(K)-1:0]              row_addr_b,
  input  logic [$clog2(N)-1:0]              col_addr_b,
  input  logic                              matrix_b_re,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0] data_out_a,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0] data_out_b,
  output logic                              do_mac,
  input  logic                              mac_done,
  output logic                              bank_busy,
  output logic                              run_done
);

  localparam int DW      = DATA_WIDTH_INIT_MATRIX;
  localparam int ARW     = $clog2(M);
  localparam int ACW     = $clog2(K);
  localparam int BRW     = $clog2(K);
  localparam int BCW     = $clog2(N);
  localparam int A_WORDS = M * K;
  localparam int B_WORDS = K * N;
  localparam int MAXW    = (A_WORDS > B_WORDS) ? A_WORDS : B_WORDS;
  localparam int CNT_W   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               xfer, last_a, last_b;
  int unsigned        cnt_u;
  logic [ARW-1:0]     wa_row;
  logic [ACW-1:0]     wa_col;
  logic [BRW-1:0]     wb_row;
  logic [BCW-1:0]     wb_col;
  logic               a_in_range, b_in_range;

  logic [DW-1:0] mem_a [M][K];
  logic [DW-1:0] mem_b [K][N];

  assign xfer   = load_valid && load_ready;
  assign last_a = (cnt == CNT_W'(A_WORDS - 1));
  assign last_b = (cnt == CNT_W'(B_WORDS - 1));

  always_comb begin
    cnt_u  = 32'(cnt);
    wa_row = ARW'(cnt_u / K);
    wa_col = ACW'(cnt_u % K);
    wb_row = BRW'(cnt_u / N);
    wb_col = BCW'(cnt_u % N);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start)      state_nxt = LOAD_A;
      LOAD_A:  if (xfer && last_a)  state_nxt = LOAD_B;
      LOAD_B:  if (xfer && last_b)  state_nxt = RUN;
      RUN:     if (mac_done)        state_nxt = DRAIN;
      DRAIN:                        state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == LOAD_A) || (state == LOAD_B);
    do_mac     = (state == RUN);
    bank_busy  = (state != IDLE);
    run_done   = (state == DRAIN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE:   if (load_start) cnt <= '0;
        LOAD_A: if (xfer)       cnt <= last_a ? '0 : cnt + 1'b1;
        LOAD_B: if (xfer)       cnt <= last_b ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is deliberately unreset so contents survive resetn.
  always_ff @(posedge clk) begin
    if (state == LOAD_A && xfer) mem_a[wa_row][wa_col] <= load_data;
    if (state == LOAD_B && xfer) mem_b[wb_row][wb_col] <= load_data;
  end

  // Out-of-range addresses only occur for non-power-of-2 dimensions.
  assign a_in_range = (32'(row_addr_a) < M) && (32'(col_addr_a) < K);
  assign b_in_range = (32'(row_addr_b) < K) && (32'(col_addr_b) < N);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out_a <= '0;
      data_out_b <= '0;
    end else begin
      if (matrix_a_re) data_out_a <= a_in_range ? mem_a[row_addr_a][col_addr_a] : '0;
      if (matrix_b_re) data_out_b <= b_in_range ? mem_b[row_addr_b][col_addr_b] : '0;
    end
  end

endmodule
